// File: rtl/axi_sram_wr_bridge.sv
// axi_sram_wr_bridge
//   AXI3 write-channel slave that accepts one burst at a time on AW/W.
//   Each accepted W beat becomes one single-cycle SRAM byte-enable write.
//   One B response is returned per burst.
//
// Ports
//   aclk, areset        clock, asynchronous active-high reset
//   m_aw*               write address channel (addr, burst, id, len, size, valid/ready)
//   m_w*                write data channel (data, strb, id (ignored), last, valid/ready)
//   m_b*                write response channel (id, resp, valid/ready)
//   ram_waddr/wdata/wen SRAM write port; wen==0 means no write this cycle
module axi_sram_wr_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   m_awaddr,
  input  logic [1:0]              m_awburst,
  input  logic [ID_WIDTH-1:0]     m_awid,
  input  logic [3:0]              m_awlen,
  input  logic [2:0]              m_awsize,
  input  logic                    m_awvalid,
  output logic                    m_awready,
  input  logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic [ID_WIDTH-1:0]     m_wid,
  input  logic                    m_wlast,
  input  logic                    m_wvalid,
  output logic                    m_wready,
  output logic [ID_WIDTH-1:0]     m_bid,
  output logic [1:0]              m_bresp,
  output logic                    m_bvalid,
  input  logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   ram_waddr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic [DATA_WIDTH/8-1:0] ram_wen
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int SIZE_MAX = $clog2(STRB_W);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [3:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  wrap_len_ok;
  logic                  aw_bad;
  logic [1:0]            aw_burst_eff;
  logic                  beat;
  logic                  last_beat;

  // W-channel ID is accepted but never compared against AWID.
  logic unused_wid;
  assign unused_wid = ^m_wid;

  // Address of the beat after `addr` for the (already sanitised) burst type.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [1:0]            burst,
    input logic [3:0]            len,
    input logic [2:0]            size
  );
    logic [ADDR_WIDTH-1:0] step, total, lower, inc;
    step  = ADDR_WIDTH'(1) << size;
    total = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
    lower = addr & ~(total - ADDR_WIDTH'(1));
    inc   = addr + step;
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (inc == lower + total) ? lower : inc;
      default: next_addr = (addr & ~(step - ADDR_WIDTH'(1))) + step;
    endcase
  endfunction

  // Reserved bursts and WRAP with an illegal length run as INCR but are flagged.
  assign wrap_len_ok  = (m_awlen == 4'd1) || (m_awlen == 4'd3) ||
                        (m_awlen == 4'd7) || (m_awlen == 4'd15);
  assign aw_bad       = (m_awburst == 2'b11) ||
                        ((m_awburst == 2'b10) && !wrap_len_ok) ||
                        (m_awsize > 3'(SIZE_MAX));
  assign aw_burst_eff = ((m_awburst == 2'b11) ||
                         ((m_awburst == 2'b10) && !wrap_len_ok)) ? 2'b01 : m_awburst;

  assign beat      = (state_q == DATA) && m_wvalid;
  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    id_d      = id_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    bresp_d   = bresp_q;
    case (state_q)
      IDLE: begin
        if (m_awvalid && awready_q) begin
          addr_d  = m_awaddr;
          id_d    = m_awid;
          len_d   = m_awlen;
          size_d  = m_awsize;
          burst_d = aw_burst_eff;
          cnt_d   = 4'd0;
          err_d   = aw_bad;
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat) begin
          addr_d = next_addr(addr_q, burst_q, len_q, size_q);
          cnt_d  = cnt_q + 4'd1;
          if (m_wlast != last_beat) err_d = 1'b1;
          if (last_beat) begin
            state_d = RESP;
            bresp_d = err_d ? 2'b10 : 2'b00;
          end
        end
      end
      RESP: begin
        if (m_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered copies of the next state.
    awready_d = (state_d == IDLE);
    wready_d  = (state_d == DATA);
    bvalid_d  = (state_d == RESP);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= 4'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'b00;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign m_awready = awready_q;
  assign m_wready  = wready_q;
  assign m_bvalid  = bvalid_q;
  assign m_bresp   = bresp_q;
  assign m_bid     = id_q;

  // SRAM port is combinational from the current beat.
  assign ram_waddr = addr_q;
  assign ram_wdata = m_wdata;
  assign ram_wen   = beat ? m_wstrb : '0;

endmodule

// File: tb/tb_axi_sram_wr_bridge.sv
// Testbench for axi_sram_wr_bridge: directed bursts from the test plan followed
// by randomized bursts; expected SRAM writes and B responses are queued by the
// stimulus and consumed by an independent monitor.
module tb_axi_sram_wr_bridge;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] m_awaddr;
  logic [1:0]  m_awburst;
  logic [3:0]  m_awid;
  logic [3:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [3:0]  m_wid;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready;
  logic [3:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wen;

  axi_sram_wr_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
    .aclk(aclk), .areset(areset),
    .m_awaddr(m_awaddr), .m_awburst(m_awburst), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wid(m_wid), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] wen; } wr_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;

  wr_t wq[$];
  b_t  bq[$];
  int  n_pass = 0;
  int  n_total = 0;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference address of beat i, computed directly from the burst rules.
  function automatic logic [31:0] addr_of(input logic [31:0] start, input logic [1:0] eb,
                                          input logic [3:0] len, input logic [2:0] size, input int i);
    logic [31:0] step, total, lower, off;
    step  = 32'd1 << size;
    total = (32'(len) + 32'd1) * step;
    if (eb == 2'b00) return start;
    if (eb == 2'b10) begin
      lower = start - (start % total);
      off   = (start - lower + 32'(i) * step) % total;
      return lower + off;
    end
    if (i == 0) return start;
    return (start - (start % step)) + 32'(i) * step;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  wr_t mw;
  b_t  mb;
  bit  prev_whs = 0;
  bit  prev_bvalid = 0;
  bit  prev_bhs = 0;
  always @(negedge aclk) begin
    if (areset) begin
      chk("rst_awready", m_awready == 1'b0, 64'(m_awready), 64'd0);
      chk("rst_wready", m_wready == 1'b0, 64'(m_wready), 64'd0);
      chk("rst_bvalid", m_bvalid == 1'b0, 64'(m_bvalid), 64'd0);
      chk("rst_wen", ram_wen == 4'd0, 64'(ram_wen), 64'd0);
      chk("rst_bresp_bid", {m_bresp, m_bid} == 6'd0, 64'({m_bresp, m_bid}), 64'd0);
      prev_whs = 0; prev_bvalid = 0; prev_bhs = 0;
    end else begin
      if (m_wvalid && m_wready) begin
        if (wq.size() == 0) chk("unexpected_write", 1'b0, 64'(ram_waddr), 64'd0);
        else begin
          mw = wq.pop_front();
          chk("ram_waddr", ram_waddr == mw.addr, 64'(ram_waddr), 64'(mw.addr));
          chk("ram_wdata", ram_wdata == mw.data, 64'(ram_wdata), 64'(mw.data));
          chk("ram_wen", ram_wen == mw.wen, 64'(ram_wen), 64'(mw.wen));
        end
      end else begin
        chk("idle_wen", ram_wen == 4'd0, 64'(ram_wen), 64'd0);
      end
      if (m_bvalid) begin
        if (!prev_bvalid) chk("bvalid_after_last_beat", prev_whs, 64'(prev_whs), 64'd1);
        if (bq.size() == 0) chk("unexpected_bvalid", 1'b0, 64'(m_bid), 64'd0);
        else begin
          mb = bq[0];
          chk("bid", m_bid == mb.id, 64'(m_bid), 64'(mb.id));
          chk("bresp", m_bresp == mb.resp, 64'(m_bresp), 64'(mb.resp));
          if (m_bready) void'(bq.pop_front());
        end
      end
      if (prev_bhs) chk("awready_after_b", m_awready == 1'b1, 64'(m_awready), 64'd1);
      prev_whs    = m_wvalid && m_wready;
      prev_bvalid = m_bvalid;
      prev_bhs    = m_bvalid && m_bready;
    end
  end

  task automatic do_burst(input logic [31:0] addr, input logic [1:0] burst, input logic [3:0] len,
                          input logic [2:0] size, input logic [3:0] id, input int bubble_after,
                          input int flip_beat, input int bhold, input int abort_after,
                          input logic [15:0] strb_seq, input logic [31:0] data0);
    logic [1:0] eb;
    bit wrap_ok, err, got;
    logic [15:0] sseq;
    sseq = strb_seq;
    wrap_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    eb  = (burst == 2'b11 || (burst == 2'b10 && !wrap_ok)) ? 2'b01 : burst;
    err = (burst == 2'b11) || (burst == 2'b10 && !wrap_ok) || (size > 3'd2) ||
          (flip_beat >= 0 && flip_beat <= int'(len));
    if (abort_after < 0) bq.push_back('{id, err ? 2'b10 : 2'b00});
    m_bready  = (bhold == 0);
    m_awaddr  = addr; m_awburst = burst; m_awlen = len; m_awsize = size; m_awid = id;
    m_awvalid = 1'b1;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge aclk);
      if (m_awready) got = 1;
    end
    @(posedge aclk); #1;
    m_awvalid = 1'b0;
    if (!got) begin chk("aw_timeout", 1'b0, 64'd0, 64'd1); return; end
    for (int i = 0; i <= int'(len); i++) begin
      m_wvalid = 1'b1;
      m_wid    = id;
      m_wdata  = (i == 0 && data0 != 32'd0) ? data0 : $urandom;
      m_wstrb  = (i < 4 && sseq != 16'd0) ? sseq[i*4 +: 4] : 4'($urandom_range(1, 15));
      m_wlast  = ((i == int'(len)) != (i == flip_beat));
      wq.push_back('{addr_of(addr, eb, len, size, i), m_wdata, m_wstrb});
      @(posedge aclk); #1;
      m_wvalid = 1'b0;
      if (i == abort_after) begin
        areset = 1'b1; m_wlast = 1'b0;
        repeat (2) begin @(posedge aclk); #1; end
        areset = 1'b0;
        @(posedge aclk); #1;
        chk("awready_after_reset", m_awready == 1'b1, 64'(m_awready), 64'd1);
        m_bready = 1'b1;
        return;
      end
      if (i == bubble_after) begin @(posedge aclk); #1; end
    end
    m_wlast = 1'b0;
    if (bhold > 0) begin
      got = 0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge aclk);
        if (m_bvalid) got = 1;
      end
      if (!got) chk("bvalid_timeout", 1'b0, 64'd0, 64'd1);
      @(posedge aclk); #1;
      repeat (bhold - 1) begin @(posedge aclk); #1; end
      m_bready = 1'b1;
    end
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge aclk);
      if (m_bvalid && m_bready) got = 1;
    end
    if (!got) chk("b_timeout", 1'b0, 64'd0, 64'd1);
    @(posedge aclk); #1;
    m_bready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  b;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [31:0] a;
    int flip, bub;
    areset = 1'b1;
    m_awaddr = '0; m_awburst = '0; m_awid = '0; m_awlen = '0; m_awsize = '0; m_awvalid = 1'b0;
    m_wdata = '0; m_wstrb = '0; m_wid = '0; m_wlast = 1'b0; m_wvalid = 1'b0; m_bready = 1'b1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(posedge aclk); #1;

    do_burst(32'h100, 2'b01, 4'd0, 3'd2, 4'h5, -1, -1, 0, -1, 16'h000F, 32'hDEADBEEF);
    do_burst(32'h200, 2'b01, 4'd3, 3'd2, 4'hA,  1, -1, 3, -1, 16'h0000, 32'h0);
    do_burst(32'h38,  2'b10, 4'd3, 3'd2, 4'h3, -1, -1, 0, -1, 16'h0000, 32'h0);
    do_burst(32'h40,  2'b00, 4'd2, 3'd2, 4'h7, -1, -1, 0, -1, 16'h0C21, 32'h0);
    do_burst(32'h80,  2'b01, 4'd1, 3'd2, 4'h6, -1,  0, 0, -1, 16'h0000, 32'h0);
    do_burst(32'h90,  2'b11, 4'd3, 3'd2, 4'h9, -1, -1, 0, -1, 16'h0000, 32'h0);
    do_burst(32'h300, 2'b01, 4'd3, 3'd2, 4'h2, -1, -1, 0,  1, 16'h0000, 32'h0);
    do_burst(32'h400, 2'b01, 4'd1, 3'd2, 4'h4, -1, -1, 0, -1, 16'h0000, 32'h0);

    for (int t = 0; t < 40; t++) begin
      b    = 2'($urandom_range(0, 3));
      len  = 4'($urandom_range(0, 15));
      size = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      a    = $urandom;
      if (b == 2'b10) a = a & ~((32'd1 << size) - 32'd1);
      flip = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      bub  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(len))) : -1;
      do_burst(a, b, len, size, 4'($urandom_range(0, 15)), bub, flip,
               int'($urandom_range(0, 3)), -1, 16'h0000, 32'h0);
    end

    repeat (3) begin @(posedge aclk); #1; end
    chk("write_queue_drained", wq.size() == 0, 64'(wq.size()), 64'd0);
    chk("b_queue_drained", bq.size() == 0, 64'(bq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_sram_wr_bridge.md
# axi_sram_wr_bridge

Write-channel counterpart of the AXI-to-SRAM read bridge. It is an AXI3 slave that accepts one write burst at a time on AW/W, drives the single-cycle SRAM byte-enable write port once per accepted beat, and returns one B response per burst. It sits between the core's AXI master and the SRAM write port, in parallel with the read bridge on the same SRAM.

## Interface
- ADDR_WIDTH, 32, AW address and SRAM write address width (byte address)
- DATA_WIDTH, 32, W data width; strobe width is DATA_WIDTH/8
- ID_WIDTH, 4, AWID/WID/BID width
- aclk  in  1  clock; all logic is on the rising edge
- areset  in  1  asynchronous, active-high reset
- m_awaddr  in  ADDR_WIDTH  burst start byte address
- m_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- m_awid  in  ID_WIDTH  burst ID, echoed on m_bid
- m_awlen  in  4  beats minus 1 (AXI3, 1..16 beats)
- m_awsize  in  3  log2 bytes per beat, at most log2(DATA_WIDTH/8)
- m_awvalid / m_awready  in / out  1  AW handshake
- m_wdata  in  DATA_WIDTH  beat data
- m_wstrb  in  DATA_WIDTH/8  byte strobes
- m_wid  in  ID_WIDTH  unchecked
- m_wlast  in  1  last-beat marker, checked
- m_wvalid / m_wready  in / out  1  W handshake
- m_bid  out  ID_WIDTH  latched AWID
- m_bresp  out  2  00 OKAY, 10 SLVERR
- m_bvalid / m_bready  out / in  1  B handshake
- ram_waddr  out  ADDR_WIDTH  SRAM write byte address
- ram_wdata  out  DATA_WIDTH  SRAM write data
- ram_wen  out  DATA_WIDTH/8  SRAM byte write enables; all zero means no write

## Operation
- FSM has three states: IDLE, DATA, RESP. Reset puts it in IDLE.
- **IDLE**
  - m_awready=1, m_wready=0, m_bvalid=0.
  - On m_awvalid&m_awready: latch addr, id, len, size, burst; clear the beat counter and error flag; go to DATA.
- **DATA**
  - m_wready=1, m_awready=0.
  - Each cycle with m_wvalid=1 is a beat:
    - ram_wen=m_wstrb, ram_waddr=current addr, ram_wdata=m_wdata, all combinational in the same cycle.
    - Otherwise ram_wen=0.
  - After each beat the address advances by step=1<<size:
    - FIXED: address unchanged.
    - INCR: next = (addr & ~(step-1)) + step. The first beat may be unaligned; later beats are aligned.
    - WRAP: total=(len+1)<<size, lower=addr & ~(total-1). If addr+step equals lower+total, next=lower; else next=addr+step.
  - The beat counter counts 0..len. The beat with count==len is the last beat; after it, go to RESP.
  - The error flag is set when:
    - m_wlast is asserted on a non-final beat;
    - m_wlast is deasserted on the final beat;
    - burst is 11 (the burst is executed as INCR);
    - burst is WRAP with len not in {1,3,7,15} (executed as INCR);
    - m_awsize > log2(DATA_WIDTH/8). Writes still occur.
- **RESP**
  - m_bvalid=1, m_bid=latched id, m_bresp=SLVERR if the error flag is set, else OKAY.
  - m_bvalid, m_bid and m_bresp are held stable until m_bready. On m_bvalid&m_bready go to IDLE.
- W beats arriving before the AW handshake are stalled, because m_wready=0 in IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH.

## Timing
- **Reset values:** m_awready=0 while areset is high, then 1 in IDLE. m_wready=0, m_bvalid=0, m_bresp=00, m_bid=0, ram_wen=0; ram_waddr/ram_wdata are don't-care with wen=0.
- **Reset mid-burst:** the FSM goes to IDLE immediately and asynchronously. The burst is abandoned and no B response is issued.
- **Burst latency with continuous m_wvalid:**
  - AW handshake in cycle N.
  - Beats in cycles N+1 .. N+1+len.
  - m_bvalid in cycle N+2+len.
  - If m_bready=1, IDLE in N+3+len, so m_awready=1 again.
- W bubbles (m_wvalid=0) stretch DATA one cycle each and produce no SRAM write.
- m_bready held low holds RESP indefinitely; m_awready stays 0 throughout.
- SRAM write latency is zero: data is visible to the read bridge from the cycle after the beat.

## Test plan
- INCR single beat: awaddr=0x100, len=0, size=2, wdata=0xDEADBEEF, wstrb=0xF, wlast=1 -> ram_wen=0xF at 0x100 in N+1; bvalid in N+2 with bresp=00 and bid=awid.
- INCR 4-beat with a wvalid bubble after beat 1 and bready low for 3 cycles -> writes at 0x200/204/208/20C; no write during the bubble; bvalid held 3 cycles with bid stable.
- WRAP len=3, size=2, awaddr=0x38 -> addresses 0x38, 0x3C, 0x30, 0x34; bresp=00.
- FIXED len=2 at 0x40, strobes 0x1/0x2/0xC -> three writes to 0x40 with those ram_wen values.
- wlast early on beat 0 of a len=1 burst -> both beats still written; bresp=10. Separately, burst=11 -> INCR addresses; bresp=10.
- areset pulse mid-burst after beat 1 of len=3 -> no further ram_wen, no bvalid; m_awready=1 after release; the next burst completes with OKAY.
